// File: rtl/pipeline_ctrl.sv
// Front-end pipeline controller: redirect arbitration, stage stall/flush, fence drain.
// Optional build macro PIPE_CTRL_PERF_EN adds redirect and stall performance counters.
module pipeline_ctrl #(
   parameter int PC_WIDTH     = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_be_stall,
   input  logic                i_be_empty,
   input  logic                i_exc_valid,
   input  logic [PC_WIDTH-1:0] i_exc_pc,
   input  logic                i_br_valid,
   input  logic [PC_WIDTH-1:0] i_br_pc,
   input  logic                i_fence_valid,
   input  logic [PC_WIDTH-1:0] i_fence_pc,
   output logic                o_fetch_stall,
   output logic                o_decode_stall,
   output logic                o_fetch_flush,
   output logic                o_decode_flush,
   output logic                o_redirect_valid,
   output logic [PC_WIDTH-1:0] o_redirect_pc,
   output logic [1:0]          o_state,
   output logic [31:0]         o_perf_flushes,
   output logic [31:0]         o_perf_stall_cycles
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

   logic [1:0]          state_q;
   logic [CW-1:0]       cnt_q;
   logic                redirect_q;
   logic [PC_WIDTH-1:0] redirect_pc_q;
   logic [PC_WIDTH-1:0] fence_pc_q;

   logic                is_flush;
   logic                is_drain;
   logic                is_run;
   logic                take;
   logic                go_drain;
   logic [PC_WIDTH-1:0] take_pc;

   // Encoding 3 is unreachable and behaves as RUN.
   assign is_flush = (state_q == ST_FLUSH);
   assign is_drain = (state_q == ST_DRAIN);
   assign is_run   = !is_flush && !is_drain;

   always_comb begin
      take     = 1'b0;
      go_drain = 1'b0;
      take_pc  = i_exc_pc;
      unique case (1'b1)
         is_flush: begin
            take = i_exc_valid;
         end
         is_drain: begin
            take = i_exc_valid | i_br_valid | i_be_empty;
            take_pc = i_exc_valid ? i_exc_pc :
                      i_br_valid  ? i_br_pc  : fence_pc_q;
         end
         default: begin
            take     = i_exc_valid | i_br_valid;
            take_pc  = i_exc_valid ? i_exc_pc : i_br_pc;
            go_drain = i_fence_valid & !take;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         fence_pc_q    <= '0;
      end else begin
         redirect_q <= 1'b0;
         if (take) begin
            state_q       <= ST_FLUSH;
            cnt_q         <= CNT_LOAD;
            redirect_q    <= 1'b1;
            redirect_pc_q <= take_pc;
         end else if (go_drain) begin
            state_q    <= ST_DRAIN;
            fence_pc_q <= i_fence_pc;
         end else if (is_flush) begin
            if (cnt_q == '0) state_q <= ST_RUN;
            else             cnt_q   <= cnt_q - 1'b1;
         end
      end
   end

   assign o_fetch_stall    = i_be_stall | !is_run;
   assign o_decode_stall   = i_be_stall | !is_run;
   assign o_fetch_flush    = is_flush;
   assign o_decode_flush   = is_flush;
   assign o_redirect_valid = redirect_q;
   assign o_redirect_pc    = redirect_pc_q;
   assign o_state          = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_flushes_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         perf_flushes_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (redirect_q)     perf_flushes_q <= perf_flushes_q + 1'b1;
         if (o_decode_stall) perf_stall_q   <= perf_stall_q + 1'b1;
      end
   end

   assign o_perf_flushes      = perf_flushes_q;
   assign o_perf_stall_cycles = perf_stall_q;
`else
   assign o_perf_flushes      = '0;
   assign o_perf_stall_cycles = '0;
`endif

endmodule
